rf_write_buffer: RTL
====================

Name: rf_write_buffer

Overview:
- Write-side companion to the MIPS core register file (`regfile`).
- Accepts writeback results (destination register, data) over a valid/ready handshake and queues them in a small FIFO.
- Drains the FIFO one entry per cycle into the single synchronous register-file write port.
- Gives read-stage logic a forwarding lookup over still-pending writes, so operand reads see the newest value before it reaches the register array.

Parameters:
DEPTH, 4, number of pending-write entries (power of two, at least 2)
AW, 5, register address width
DW, 32, data width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  writeback request present
in_ready  output  1  buffer can accept a request this cycle
in_addr  input  AW  destination register
in_data  input  DW  value to write
wb_stall  input  1  inhibits draining this cycle (write port borrowed elsewhere)
rf_wr  output  1  register-file write enable
rf_waddr  output  AW  register-file write address
rf_din  output  DW  register-file write data
q_addr1  input  AW  lookup address, operand 1
q_hit1  output  1  a pending write to q_addr1 exists
q_data1  output  DW  newest pending data for q_addr1
q_addr2  input  AW  lookup address, operand 2
q_hit2  output  1  a pending write to q_addr2 exists
q_data2  output  DW  newest pending data for q_addr2
count  output  clog2(DEPTH)+1  number of pending entries
empty  output  1  count == 0

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data}, with head pointer, tail pointer and count register. Pointers wrap modulo DEPTH.
- Reset: when rst is 1 at a rising edge, head, tail and count clear to 0. All pending entries are discarded, including mid-drain.
- Outputs after reset: rf_wr=0, in_ready=1, empty=1, count=0, q_hit1=q_hit2=0. q_data*, rf_waddr and rf_din read as 0 when there is no hit or no valid head.
- Accept rule: in_ready = (count < DEPTH). It depends only on registered count; there is no same-cycle pop-through when full.
- Push: occurs when in_valid && in_ready && in_addr != 0. The entry is written at the tail and the tail advances.
- Writes to register 0: accepted (the handshake completes) but not enqueued. They never reach rf_wr.
- Drain: rf_wr = !empty && !wb_stall (combinational). rf_waddr and rf_din show the head entry.
- Pop: occurs at the rising edge where rf_wr=1. The register file captures the value on that same edge, and the head advances.
- Latency: a request accepted at edge N into an empty buffer drives rf_wr=1 during cycle N+1 and is written into the register file at edge N+1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full with wb_stall=1: in_ready=0 and nothing moves.
- Ordering: entries drain strictly in acceptance order. Repeated writes to the same register are all performed, oldest first.
- Lookup (combinational, per port):
  - q_hit = 1 if any currently pending entry (head through tail-1, including the head being written this cycle) has addr == q_addr and q_addr != 0.
  - q_data = data of the youngest matching entry.
  - A request being accepted in the current cycle is not visible until the next cycle.
- Combined read data: register-file read data muxed with the lookup (hit ? q_data : regfile dout) gives the architecturally current value every cycle.
- Arithmetic: count changes by +1, -1 or 0 per cycle and never exceeds DEPTH or drops below 0. Assertions required on both bounds.

Test Plan:
- Reset, then push (addr 5, 0xDEADBEEF) at edge 1 -> rf_wr=1, rf_waddr=5, rf_din=0xDEADBEEF during cycle 2. count=0 after edge 2, and the regfile holds 0xDEADBEEF in register 5.
- wb_stall=1; push addr 1..5 with data 0x11..0x55 -> first four accepted. in_ready=0 on the 5th; count=4.
- Release the stall -> writes to regs 1, 2, 3, 4 drain on consecutive cycles in order, then 5 once re-offered.
- Push addr 0 with data 0x1234 -> handshake completes, count stays 0, rf_wr never asserts, and q_hit for q_addr=0 stays 0.
- Stall; push (7, 0xA), then (7, 0xB), then (9, 0xC); q_addr1=7, q_addr2=9 -> q_hit1=1, q_data1=0xB, q_hit2=1, q_data2=0xC. Also check q_addr=8 -> hit=0.
- Release the stall at count=2 while pushing each cycle -> count stays 2, and drained order matches pushed order. Then stop pushing -> empty after 2 cycles.
- With 3 entries pending, assert rst for one cycle -> next cycle count=0, rf_wr=0, in_ready=1, all hits=0. No further register-file writes occur.

Source files
------------

// File: rtl/rf_write_buffer.sv
// Write-side buffer for the register file: queues writeback results, drains one per
// cycle into the single write port, and forwards still-pending data to operand reads.
module rf_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     wb_stall,
    output logic                     rf_wr,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_din,
    input  logic [AW-1:0]            q_addr1,
    output logic                     q_hit1,
    output logic [DW-1:0]            q_data1,
    input  logic [AW-1:0]            q_addr2,
    output logic                     q_hit2,
    output logic [DW-1:0]            q_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic          push;
    logic          pop;

    // Readiness looks only at the registered count, so a full buffer never pops through.
    assign in_ready = count_q < FULL_COUNT;
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign rf_wr    = !empty && !wb_stall;
    assign pop      = rf_wr;
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign rf_waddr = empty ? '0 : addr_mem[head_q];
    assign rf_din   = empty ? '0 : data_mem[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_mem[tail_q] <= in_addr;
            data_mem[tail_q] <= in_data;
        end
    end

    // One forwarding lookup per read port; walking oldest to youngest lets the youngest match win.
    logic [AW-1:0] look_addr [2];
    logic          look_hit  [2];
    logic [DW-1:0] look_data [2];

    assign look_addr[0] = q_addr1;
    assign look_addr[1] = q_addr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_look
            logic          hit_c;
            logic [DW-1:0] data_c;

            always_comb begin
                hit_c  = 1'b0;
                data_c = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    logic [PW-1:0] idx;
                    idx = head_q + PW'(k);
                    if ((CW'(k) < count_q) && (addr_mem[idx] == look_addr[gi])
                        && (look_addr[gi] != '0)) begin
                        hit_c  = 1'b1;
                        data_c = data_mem[idx];
                    end
                end
            end

            assign look_hit[gi]  = hit_c;
            assign look_data[gi] = data_c;
        end
    endgenerate

    assign q_hit1  = look_hit[0];
    assign q_data1 = look_data[0];
    assign q_hit2  = look_hit[1];
    assign q_data2 = look_data[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= FULL_COUNT);
            assert (!(pop && (count_q == '0)));
            assert (!(push && !pop && (count_q == FULL_COUNT)));
        end
    end

endmodule
